lifo_req_arb: RTL and testbench
===============================

// Module: lifo_req_arb
// PURPOSE
//   Round-robin arbiter and sequencer sharing one lifo stack among N_REQ requesters.
//   Each requester posts a push or pop request. The arbiter grants one requester at a time.
//   For the grant it drives the stack's push/pop/din strobes and returns the popped data.
//   Sits between client ports and the single lifo instance; it is the stack's only driver.
// PARAMETERS
//   N_REQ  4  number of requesters (2..8); IDXW = $clog2(N_REQ) is a derived localparam
//   WIDTH  8  data width; matches the lifo WIDTH
// PORTS
//   clk        in   1              clock, all logic on posedge
//   rstn       in   1              reset, synchronous, active-high (1 = reset)
//   req        in   N_REQ          request per requester; held high until gnt
//   op         in   N_REQ          per requester: 1 = push, 0 = pop; held with req
//   wdata      in   N_REQ*WIDTH    push data, requester i at [i*WIDTH +: WIDTH]
//   gnt        out  N_REQ          one-hot, 1-cycle pulse: request accepted
//   rd_valid   out  N_REQ          one-hot, 1-cycle pulse: rd_data valid for that pop
//   rd_data    out  WIDTH          popped data, valid only with rd_valid
//   busy       out  1              high whenever state != IDLE
//   lifo_push  out  1              to lifo push
//   lifo_pop   out  1              to lifo pop
//   lifo_din   out  WIDTH          to lifo din
//   lifo_dout  in   WIDTH          from lifo dout (registered; valid the cycle after pop)
//   lifo_empty in   1              from lifo empty
//   lifo_full  in   1              from lifo full
// BEHAVIOUR
//   - Reset: state=IDLE, rr_ptr=0, gnt/rd_valid/lifo_push/lifo_pop/busy=0, rd_data=0, lifo_din=0.
//   - Reset mid-transaction aborts it: no strobe, gnt or rd_valid follows.
//     The lifo shares rstn, so its contents are cleared too.
//   - Eligible request:
//       push: req[i] & op[i] & !lifo_full
//       pop:  req[i] & !op[i] & !lifo_empty
//     Ineligible requests wait and are not granted.
//   - FSM states: IDLE, ISSUE, RDATA.
//   - IDLE:
//       If any request is eligible, pick the first one scanning i = rr_ptr, rr_ptr+1, ... mod N_REQ.
//       Register win_idx, win_op and win_data, then go to ISSUE. rr_ptr <= (win_idx+1) mod N_REQ.
//       Otherwise stay in IDLE.
//   - ISSUE (exactly 1 cycle):
//       gnt[win_idx]=1.
//       Push: lifo_push=1 and lifo_din=win_data, then go to IDLE.
//       Pop: lifo_pop=1, then go to RDATA.
//   - RDATA (1 cycle): rd_valid[win_idx]=1, rd_data=lifo_dout, then go to IDLE.
//   - Never assert lifo_push and lifo_pop in the same cycle. Strobes are 1 cycle wide.
//   - Latency:
//       push: req to gnt is 1 cycle.
//       pop: req to gnt is 1 cycle; gnt to rd_valid is 1 cycle.
//       Sustained throughput: one push per 2 cycles, one pop per 3 cycles.
//   - full/empty are sampled only in IDLE. Because the lifo index updates on the ISSUE edge,
//     IDLE always sees the post-operation flags.
//   - Requesters may drop req only after gnt. A new request may be raised the cycle after gnt.
// CONFIGURATION
//   LIFO_REQ_ARB_ERR_EN defined:
//     Ineligible requests (push on full, pop on empty) still take part in arbitration.
//     When such a request wins, ISSUE pulses gnt and err[win_idx] with no lifo strobe,
//     then returns to IDLE.
//     Added ports:
//       err      out  N_REQ  error pulse per requester
//       err_cnt  out  16     saturating count of rejected requests, reset 0
//   Not defined: no err/err_cnt ports; ineligible requests stall until eligible.
// TESTING
//   - Reset then idle: all outputs 0, busy=0 for 10 cycles with req=0.
//   - req0 push 8'hA5; next transaction req0 pop.
//     Expect gnt0 then lifo_push/lifo_din=A5; later rd_valid0 with rd_data=A5.
//   - req0..3 all push, held.
//     Expect grants in order 0,1,2,3, one every 2 cycles; a pop sequence then returns LIFO order.
//   - Fill to DEPTH=8, then req2 push.
//     Without the macro: no gnt2 until req1 pops.
//     With LIFO_REQ_ARB_ERR_EN: gnt2 + err2, err_cnt=1.
//   - Pop on an empty stack.
//     Without the macro: it waits; after a push by req3, the pop completes with req3's data.
//   - Assert rstn in RDATA: no rd_valid, state returns to IDLE, lifo_empty=1 after reset.

Source files
------------

// File: rtl/lifo_req_arb.sv
// rtl/lifo_req_arb.sv - round-robin arbiter sequencing N_REQ requesters onto one shared lifo
// Optional LIFO_REQ_ARB_ERR_EN: ineligible requests win arbitration and are rejected with err.
module lifo_req_arb #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       op,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rd_valid,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   busy,
    output logic                   lifo_push,
    output logic                   lifo_pop,
    output logic [WIDTH-1:0]       lifo_din,
    input  logic [WIDTH-1:0]       lifo_dout,
    input  logic                   lifo_empty,
    input  logic                   lifo_full
`ifdef LIFO_REQ_ARB_ERR_EN
    ,
    output logic [N_REQ-1:0]       err,
    output logic [15:0]            err_cnt
`endif
);

    localparam int IDXW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   win_idx;
    logic              win_op;
    logic [WIDTH-1:0]  win_data;
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  cand;
    logic              pick_vld;
    logic [IDXW-1:0]   pick_idx;
`ifdef LIFO_REQ_ARB_ERR_EN
    logic              win_err;
`endif

    function automatic logic [IDXW-1:0] wrap_idx(input int base, input int offs);
        int t;
        t = base + offs;
        if (t >= N_REQ) t = t - N_REQ;
        return IDXW'(t);
    endfunction

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req[i] & (op[i] ? !lifo_full : !lifo_empty);
        end
`ifdef LIFO_REQ_ARB_ERR_EN
        cand = req;
`else
        cand = elig;
`endif
    end

    // Scan from the farthest offset back so the one nearest rr_ptr is kept.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand[wrap_idx(int'(rr_ptr), k)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_idx(int'(rr_ptr), k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            win_idx  <= '0;
            win_op   <= 1'b0;
            win_data <= '0;
`ifdef LIFO_REQ_ARB_ERR_EN
            win_err  <= 1'b0;
            err_cnt  <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                win_idx  <= pick_idx;
                win_op   <= op[pick_idx];
                win_data <= wdata[int'(pick_idx)*WIDTH +: WIDTH];
                rr_ptr   <= wrap_idx(int'(pick_idx), 1);
`ifdef LIFO_REQ_ARB_ERR_EN
                win_err  <= !elig[pick_idx];
`endif
            end
`ifdef LIFO_REQ_ARB_ERR_EN
            if (state == ISSUE && win_err && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        rd_valid  = '0;
        rd_data   = '0;
        busy      = 1'b0;
        lifo_push = 1'b0;
        lifo_pop  = 1'b0;
        lifo_din  = '0;
`ifdef LIFO_REQ_ARB_ERR_EN
        err       = '0;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) state_nxt = ISSUE;
            end
            ISSUE: begin
                busy         = 1'b1;
                gnt[win_idx] = 1'b1;
`ifdef LIFO_REQ_ARB_ERR_EN
                if (win_err) begin
                    err[win_idx] = 1'b1;
                    state_nxt    = IDLE;
                end else
`endif
                if (win_op) begin
                    lifo_push = 1'b1;
                    lifo_din  = win_data;
                    state_nxt = IDLE;
                end else begin
                    lifo_pop  = 1'b1;
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                busy              = 1'b1;
                rd_valid[win_idx] = 1'b1;
                rd_data           = lifo_dout;
                state_nxt         = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A reset cycle aborts the transaction in flight, so nothing may leak out during it.
        if (rstn) begin
            gnt       = '0;
            rd_valid  = '0;
            rd_data   = '0;
            busy      = 1'b0;
            lifo_push = 1'b0;
            lifo_pop  = 1'b0;
            lifo_din  = '0;
`ifdef LIFO_REQ_ARB_ERR_EN
            err       = '0;
`endif
        end
    end

endmodule

// File: tb/tb_lifo_req_arb.sv
// tb/tb_lifo_req_arb.sv - directed and random checks of lifo_req_arb against a transaction model
module tb_lifo_req_arb;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req;
    logic [N-1:0]   op;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rd_valid;
    logic [W-1:0]   rd_data;
    logic           busy;
    logic           lifo_push;
    logic           lifo_pop;
    logic [W-1:0]   lifo_din;
    logic [W-1:0]   lifo_dout;
    logic           lifo_empty;
    logic           lifo_full;
`ifdef LIFO_REQ_ARB_ERR_EN
    logic [N-1:0]   err;
    logic [15:0]    err_cnt;
`endif

    always #5 clk = ~clk;

    lifo_req_arb #(.N_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .op         (op),
        .wdata      (wdata),
        .gnt        (gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .busy       (busy),
        .lifo_push  (lifo_push),
        .lifo_pop   (lifo_pop),
        .lifo_din   (lifo_din),
        .lifo_dout  (lifo_dout),
        .lifo_empty (lifo_empty),
        .lifo_full  (lifo_full)
`ifdef LIFO_REQ_ARB_ERR_EN
        ,
        .err        (err),
        .err_cnt    (err_cnt)
`endif
    );

    // Stack the DUT drives: registered dout, shares the reset.
    logic [W-1:0] mem [DEPTH];
    int           cnt;
    always @(posedge clk) begin
        if (rstn) begin
            cnt       <= 0;
            lifo_dout <= '0;
        end else if (lifo_push && cnt < DEPTH) begin
            mem[cnt] <= lifo_din;
            cnt      <= cnt + 1;
        end else if (lifo_pop && cnt > 0) begin
            lifo_dout <= mem[cnt-1];
            cnt       <= cnt - 1;
        end
    end
    assign lifo_empty = (cnt == 0);
    assign lifo_full  = (cnt == DEPTH);

    int           n_checks = 0;
    int           n_fail   = 0;
    int           mrr;
    int           merr;
    logic [W-1:0] mstack [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn  = 1'b1;
        req   = '0;
        op    = '0;
        wdata = '0;
        tick();
        tick();
        rstn = 1'b0;
        mrr  = 0;
        merr = 0;
        mstack.delete();
    endtask

    function automatic bit model_ok(input int i);
        return op[i] ? (mstack.size() < DEPTH) : (mstack.size() > 0);
    endfunction

    function automatic int predict();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mrr + k) % N;
`ifdef LIFO_REQ_ARB_ERR_EN
            if (req[i]) return i;
`else
            if (req[i] && model_ok(i)) return i;
`endif
        end
        return -1;
    endfunction

    // One arbitration round starting in IDLE; ends in IDLE.
    task automatic run_xact(input int exp_w, input int exp_d);
        int           w;
        bit           p;
        bit           e;
        logic [W-1:0] d;
        w = (exp_w >= 0) ? exp_w : predict();
        if (w < 0) begin
            tick();
            chk("no_gnt", gnt, 0);
            chk("no_busy", busy, 0);
            return;
        end
        p = op[w];
        e = !model_ok(w);
        d = p ? wdata[w*W +: W] : (e ? '0 : mstack[$]);
        if (!p && exp_d >= 0) d = W'(exp_d);
        tick();
        chk("gnt", gnt, 32'(1) << w);
        chk("busy_issue", busy, 1);
        req[w] = 1'b0;
        mrr = (w + 1) % N;
`ifdef LIFO_REQ_ARB_ERR_EN
        if (e) begin
            chk("err", err, 32'(1) << w);
            chk("no_strobe", {lifo_push, lifo_pop}, 0);
            merr++;
            tick();
            chk("err_cnt", err_cnt, merr);
            chk("idle_after_err", busy, 0);
            return;
        end
`endif
        chk("push_strobe", lifo_push, p);
        chk("pop_strobe", lifo_pop, !p);
        if (p) begin
            chk("lifo_din", lifo_din, d);
            mstack.push_back(d);
        end else begin
            void'(mstack.pop_back());
        end
        tick();
        if (!p) begin
            chk("rd_valid", rd_valid, 32'(1) << w);
            chk("rd_data", rd_data, d);
            tick();
        end
        chk("idle_busy", busy, 0);
    endtask

    task automatic set_req(input int i, input bit is_push, input logic [W-1:0] d);
        req[i]         = 1'b1;
        op[i]          = is_push;
        wdata[i*W +: W] = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        for (int c = 0; c < 10; c++) begin
            chk("reset_idle", {gnt, rd_valid, rd_data, busy, lifo_push, lifo_pop, lifo_din}, 0);
            tick();
        end

        set_req(0, 1'b1, 8'hA5);
        run_xact(0, -1);
        set_req(0, 1'b0, 8'h00);
        run_xact(0, 'hA5);

        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, W'(8'h10 + i));
        for (int i = 0; i < N; i++) run_xact(i, -1);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00);
        for (int i = 0; i < N; i++) run_xact(i, 8'h13 - i);

        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            set_req(0, 1'b1, W'(8'h80 + k));
            run_xact(0, -1);
        end
        chk("full", lifo_full, 1);
        set_req(2, 1'b1, 8'h99);
`ifdef LIFO_REQ_ARB_ERR_EN
        run_xact(2, -1);
        chk("err_cnt_one", err_cnt, 1);
`else
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("full_stall", {gnt, busy}, 0);
        end
        set_req(1, 1'b0, 8'h00);
        run_xact(1, 'h87);
        run_xact(2, -1);
        chk("refilled", cnt, DEPTH);

        do_reset();
        set_req(1, 1'b0, 8'h00);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("empty_stall", {gnt, busy}, 0);
        end
        set_req(3, 1'b1, 8'h3C);
        run_xact(3, -1);
        run_xact(1, 'h3C);
`endif

        do_reset();
        set_req(0, 1'b1, 8'h5A);
        run_xact(0, -1);
        set_req(0, 1'b0, 8'h00);
        tick();
        chk("pop_gnt", gnt, 1);
        req = '0;
        tick();
        rstn = 1'b1;
        #1;
        chk("rst_rdata_valid", rd_valid, 0);
        tick();
        rstn = 1'b0;
        mstack.delete();
        mrr = 0;
        merr = 0;
        chk("rst_empty", lifo_empty, 1);
        chk("rst_busy", busy, 0);
        tick();
        chk("rst_no_rd_valid", {rd_valid, gnt}, 0);

        do_reset();
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 2) == 1) set_req(i, 1'($urandom % 2), W'($urandom));
            end
            if (req == '0) set_req(int'($urandom % N), 1'b1, W'($urandom));
            if (predict() < 0) begin
                int j;
                run_xact(-1, -1);
                j = int'($urandom % N);
                set_req(j, mstack.size() == 0, W'($urandom));
            end
            run_xact(-1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
